// File: rtl/rr_logging_bus_marshaller_n.sv
// N-input logb packing node: compacts the valid channels of one input beat into an
// LSB-aligned word plus bit length, buffered in a 2-entry valid/ready output queue.
package rr_logging_bus_marshaller_n_pkg;
  localparam int unsigned RR_CHANNEL_WIDTH_BITS = 8;

  function automatic int unsigned rr_sum_widths(input int unsigned n, input bit [63:0] w);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < n; i++) s += int'(w[i*RR_CHANNEL_WIDTH_BITS +: RR_CHANNEL_WIDTH_BITS]);
    return s;
  endfunction
endpackage

module rr_logging_bus_marshaller_n
  import rr_logging_bus_marshaller_n_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter bit [NUM_IN-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CH_WIDTHS = {8'd32, 8'd32, 8'd32, 8'd32},
  localparam int unsigned FULL_WIDTH = rr_sum_widths(NUM_IN, 64'(CH_WIDTHS)),
  localparam int unsigned OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [FULL_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [FULL_WIDTH-1:0]   out_data,
  output logic [OFFSET_WIDTH-1:0] out_len,
  output logic [NUM_IN-1:0]       out_mask,
  input  logic                    out_ready,
  output logic [CNT_WIDTH-1:0]    pkt_cnt,
  output logic [CNT_WIDTH-1:0]    stall_cnt
);

  logic [FULL_WIDTH-1:0]   pack_data;
  logic [OFFSET_WIDTH-1:0] pack_len;

  logic [FULL_WIDTH-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic [OFFSET_WIDTH-1:0] len0_q, len0_d, len1_q, len1_d;
  logic [NUM_IN-1:0]       mask0_q, mask0_d, mask1_q, mask1_d;
  logic [1:0]              count_q, count_d;
  logic [CNT_WIDTH-1:0]    pkt_q, pkt_d, stall_q, stall_d;

  logic any_valid, enq, deq;

  // Each channel is isolated by shifting to bit 0 and masking above its width,
  // then OR-ed in at the running length so valid channels land back to back.
  always_comb begin
    int unsigned off;
    logic [FULL_WIDTH-1:0] chan;
    off       = 0;
    chan      = '0;
    pack_data = '0;
    pack_len  = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      chan = in_data >> off;
      for (int unsigned b = 0; b < FULL_WIDTH; b++) begin
        if (b >= 32'(CH_WIDTHS[i])) chan[b] = 1'b0;
      end
      if (in_valid[i]) begin
        pack_data = pack_data | (chan << pack_len);
        pack_len  = pack_len + OFFSET_WIDTH'(CH_WIDTHS[i]);
      end
      off = off + 32'(CH_WIDTHS[i]);
    end
  end

  assign any_valid = |in_valid;
  assign in_ready  = (count_q != 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign enq       = any_valid && in_ready;
  assign deq       = out_valid && out_ready;

  always_comb begin
    data0_d = data0_q;
    len0_d  = len0_q;
    mask0_d = mask0_q;
    data1_d = data1_q;
    len1_d  = len1_q;
    mask1_d = mask1_q;
    count_d = count_q;
    pkt_d   = pkt_q;
    stall_d = stall_q;

    // Pop first, then push into the first free slot of the post-pop occupancy.
    if (deq) begin
      data0_d = data1_q;
      len0_d  = len1_q;
      mask0_d = mask1_q;
      data1_d = '0;
      len1_d  = '0;
      mask1_d = '0;
      count_d = count_q - 2'd1;
    end
    if (enq) begin
      if (count_d == 2'd0) begin
        data0_d = pack_data;
        len0_d  = pack_len;
        mask0_d = in_valid;
      end else begin
        data1_d = pack_data;
        len1_d  = pack_len;
        mask1_d = in_valid;
      end
      count_d = count_d + 2'd1;
    end

    if (deq && (pkt_q != '1)) pkt_d = pkt_q + CNT_WIDTH'(1);
    if (any_valid && !in_ready && (stall_q != '1)) stall_d = stall_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q <= '0;
      len0_q  <= '0;
      mask0_q <= '0;
      data1_q <= '0;
      len1_q  <= '0;
      mask1_q <= '0;
      count_q <= '0;
      pkt_q   <= '0;
      stall_q <= '0;
    end else begin
      data0_q <= data0_d;
      len0_q  <= len0_d;
      mask0_q <= mask0_d;
      data1_q <= data1_d;
      len1_q  <= len1_d;
      mask1_q <= mask1_d;
      count_q <= count_d;
      pkt_q   <= pkt_d;
      stall_q <= stall_d;
    end
  end

  assign out_data  = data0_q;
  assign out_len   = len0_q;
  assign out_mask  = mask0_q;
  assign pkt_cnt   = pkt_q;
  assign stall_cnt = stall_q;

endmodule
